// File: rtl/uart_pkg.sv
// Shared types for the oversampled UART receiver: config encodings, FSM states
// and the FIFO entry layout.
package uart_pkg;

    typedef enum logic [1:0] {
        DNUM_5 = 2'b00,
        DNUM_6 = 2'b01,
        DNUM_7 = 2'b10,
        DNUM_8 = 2'b11
    } dnum_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_PUSH,
        ST_BREAK
    } state_e;

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Index of the final data bit: 4 for 5-bit frames up to 7 for 8-bit frames.
    function automatic logic [2:0] last_bit_idx(input dnum_e d);
        return 3'd4 + {1'b0, d};
    endfunction

    function automatic logic parity_enabled(input parity_e p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable. A pop frees a slot for a push in the same cycle.
module uart_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (5-8 data bits, parity, 1/2 stop) feeding a FWFT FIFO.
// Optional UART_RX_BREAK_DETECT_EN adds break_out and suppresses pushing break frames.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             enable_in,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] clk_div_in,
    input  logic [1:0]       d_num_in,
    input  logic [1:0]       parity_in,
    input  logic             s_num_in,
    input  logic             n_rd_in,
    output logic [7:0]       data_out,
    output logic             parity_error_out,
    output logic             frame_error_out,
    output logic             overrun_error_out,
    output logic             rx_rdy_out,
    output logic [LVL_W-1:0] fifo_level_out
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic             break_out
`endif
);

    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam int AW  = $clog2(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_eff;
    logic [SW-1:0]    samp_q, samp_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       smp_q, smp_d;
    logic             perr_q, perr_d, ferr_q, ferr_d;
    dnum_e            dnum_q, dnum_d;
    parity_e          par_q, par_d;
    logic             stop2_q, stop2_d;
    logic             overrun_q, overrun_d;
    logic             tick, maj, sample_now, bit_end, push, is_break;
    rx_entry_t        wentry, head;
    logic [ENTRY_W-1:0] rdata;
    logic             fifo_full, fifo_empty, pop_ok;
    logic [AW:0]      fifo_lvl;

`ifdef UART_RX_BREAK_DETECT_EN
    logic             pbit_q, pbit_d, brk_q, brk_d;
    assign is_break = (shift_q == '0) && !maj && !(parity_enabled(par_q) && pbit_q);
    assign break_out = brk_q;
`else
    assign is_break = 1'b0;
`endif

    assign div_eff    = (clk_div_in == '0) ? DIV_W'(1) : clk_div_in;
    assign tick       = (state_q != ST_IDLE) && (div_cnt_q >= div_eff - 1'b1);
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
    assign sample_now = tick && (samp_q == SW'(MID + 1));
    assign bit_end    = tick && (samp_q == SW'(OVERSAMPLE - 1));

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        samp_d    = samp_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        dnum_d    = dnum_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        push      = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        pbit_d    = pbit_q;
        brk_d     = 1'b0;
`endif
        if (state_q != ST_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) samp_d = (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + 1'b1;
            if (tick && samp_q == SW'(MID - 1)) smp_d[0] = rx_s2_q;
            if (tick && samp_q == SW'(MID))     smp_d[1] = rx_s2_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable_in && rx_prev_q && !rx_s2_q) begin
                    state_d   = ST_START;
                    div_cnt_d = '0;
                    samp_d    = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    dnum_d    = dnum_e'(d_num_in);
                    par_d     = parity_e'(parity_in);
                    stop2_d   = s_num_in;
                end
            end
            ST_START: begin
                if (tick && samp_q == SW'(MID) && rx_s2_q) state_d = ST_IDLE;
                else if (bit_end)                          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sample_now) shift_d[bit_cnt_q] = maj;
                if (bit_end) begin
                    if (bit_cnt_q == last_bit_idx(dnum_q)) begin
                        bit_cnt_d = '0;
                        state_d   = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_now) begin
                    perr_d = (^shift_q) ^ maj ^ (par_q == PAR_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                    pbit_d = maj;
`endif
                end
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave at the last stop sample so a back-to-back start edge is not missed.
                if (sample_now) begin
                    ferr_d = ferr_q | ~maj;
                    if (bit_cnt_q == 3'd0 && is_break) begin
`ifdef UART_RX_BREAK_DETECT_EN
                        brk_d   = 1'b1;
`endif
                        state_d = ST_BREAK;
                    end else if (bit_cnt_q == {2'b00, stop2_q}) begin
                        state_d = ST_PUSH;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PUSH: begin
                push    = enable_in;
                state_d = ST_IDLE;
            end
            ST_BREAK: begin
                if (rx_s2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable_in) state_d = ST_IDLE;
    end

    assign pop_ok = !n_rd_in && !fifo_empty;

    always_comb begin
        overrun_d = overrun_q;
        if (pop_ok)                 overrun_d = 1'b0;
        else if (push && fifo_full) overrun_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q   <= ST_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            div_cnt_q <= '0;
            samp_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            smp_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            dnum_q    <= DNUM_5;
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            pbit_q    <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            div_cnt_q <= div_cnt_d;
            samp_q    <= samp_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            dnum_q    <= dnum_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            pbit_q    <= pbit_d;
            brk_q     <= brk_d;
`endif
        end
    end

    assign wentry.parity_err = perr_q;
    assign wentry.frame_err  = ferr_q;
    assign wentry.data       = shift_q;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .push_i     (push),
        .wdata_i    (wentry),
        .pop_i      (!n_rd_in),
        .rdata_o    (rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_lvl)
    );

    assign head              = rx_entry_t'(rdata);
    assign data_out          = fifo_empty ? 8'h00 : head.data;
    assign parity_error_out  = !fifo_empty && head.parity_err;
    assign frame_error_out   = !fifo_empty && head.frame_err;
    assign rx_rdy_out        = !fifo_empty;
    assign overrun_error_out = overrun_q;
    assign fifo_level_out    = LVL_W'(fifo_lvl);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a serial transmitter task drives rx_in and
// queues expected entries; a monitor pops and compares whatever the FIFO presents.
module tb_uart_rx_fifo;

    typedef struct packed {
        logic       pe;
        logic       fe;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        enable;
    logic        rx;
    logic [15:0] clk_div;
    logic [1:0]  d_num;
    logic [1:0]  parity;
    logic        s_num;
    logic        n_rd;
    logic [7:0]  data_out;
    logic        perr, ferr, ovr, rdy;
    logic [3:0]  level;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        break_out;
    int          brk_cnt = 0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   pop_reqs = 0;
    int   pops_done = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk_in            (clk),
        .n_reset_in        (n_reset),
        .enable_in         (enable),
        .rx_in             (rx),
        .clk_div_in        (clk_div),
        .d_num_in          (d_num),
        .parity_in         (parity),
        .s_num_in          (s_num),
        .n_rd_in           (n_rd),
        .data_out          (data_out),
        .parity_error_out  (perr),
        .frame_error_out   (ferr),
        .overrun_error_out (ovr),
        .rx_rdy_out        (rdy),
        .fifo_level_out    (level)
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        .break_out         (break_out)
`endif
    );

`ifdef UART_RX_BREAK_DETECT_EN
    always @(negedge clk) if (break_out) brk_cnt++;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Monitor: pops the head whenever enabled and compares it against the queue.
    initial begin
        exp_t e;
        n_rd = 1'b1;
        forever begin
            @(negedge clk);
            if (!n_rd) begin
                n_rd = 1'b1;
            end else if (mon_en && rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame got=%0h exp=none", {perr, ferr, data_out});
                end else begin
                    e = q.pop_front();
                    chk("frame", 32'({perr, ferr, data_out}), 32'(e));
                end
                n_rd = 1'b0;
            end else if (pops_done < pop_reqs) begin
                pops_done++;
                n_rd = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int nb, input int par,
                        input bit st2, input bit bad_par, input bit bad_stop);
        int   bc;
        logic p;
        bc = ((clk_div == 16'd0) ? 1 : int'(clk_div)) * 16;
        p  = 1'b0;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = b[i];
            p  = p ^ b[i];
            repeat (bc) @(negedge clk);
        end
        if (par == 1 || par == 2) begin
            rx = p ^ (par == 2) ^ bad_par;
            repeat (bc) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (bc) @(negedge clk);
        rx = 1'b1;
        if (st2) repeat (bc) @(negedge clk);
        repeat (bc) @(negedge clk);
    endtask

    task automatic expect_frame(input logic pe, input logic fe, input logic [7:0] d);
        exp_t e;
        e.pe = pe;
        e.fe = fe;
        e.d  = d;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20000 && q.size() > 0; i++) @(negedge clk);
        chk(nm, 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_once();
        pop_reqs++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx, mask;
        n_reset = 1'b0;
        enable  = 1'b1;
        rx      = 1'b1;
        clk_div = 16'd27;
        d_num   = 2'b11;
        parity  = 2'b00;
        s_num   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(data_out), 32'h0);
        chk("rst_perr",  32'(perr),     32'h0);
        chk("rst_ferr",  32'(ferr),     32'h0);
        chk("rst_ovr",   32'(ovr),      32'h0);
        chk("rst_rdy",   32'(rdy),      32'h0);
        chk("rst_level", 32'(level),    32'h0);
        n_reset = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 at the nominal divider
        send(8'hA5, 8, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_rdy",   32'(rdy),      32'h1);
        chk("a5_data",  32'(data_out), 32'hA5);
        chk("a5_perr",  32'(perr),     32'h0);
        chk("a5_ferr",  32'(ferr),     32'h0);
        chk("a5_level", 32'(level),    32'h1);
        pop_once();
        chk("a5_pop_rdy",   32'(rdy),      32'h0);
        chk("a5_pop_data",  32'(data_out), 32'h0);
        chk("a5_pop_level", 32'(level),    32'h0);

        // Format sweep; upper bits beyond the data width must be dropped
        clk_div = 16'd3;
        mon_en  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 3; p++) begin
                for (int s = 0; s < 2; s++) begin
                    d_num  = 2'(d);
                    parity = 2'(p);
                    s_num  = s[0];
                    tx     = 8'hE0 | 8'(d * 6 + p * 2 + s);
                    mask   = 8'((16'd1 << (d + 5)) - 16'd1);
                    expect_frame(1'b0, 1'b0, tx & mask);
                    send(tx, d + 5, p, s[0], 1'b0, 1'b0);
                end
            end
        end
        drain("sweep_drain");

        // Divider 0 behaves as 1
        clk_div = 16'd0;
        d_num   = 2'b11;
        parity  = 2'b00;
        s_num   = 1'b0;
        expect_frame(1'b0, 1'b0, 8'hC3);
        send(8'hC3, 8, 0, 1'b0, 1'b0, 1'b0);
        drain("div0_drain");
        clk_div = 16'd3;

        // 7E1 error injection
        d_num  = 2'b10;
        parity = 2'b01;
        expect_frame(1'b1, 1'b0, 8'h35);
        send(8'h35, 7, 1, 1'b0, 1'b1, 1'b0);
        expect_frame(1'b0, 1'b1, 8'h12);
        send(8'h12, 7, 1, 1'b0, 1'b0, 1'b1);
        drain("7e1_drain");

        // Overrun: nine frames into an eight-deep FIFO
        mon_en = 1'b0;
        d_num  = 2'b11;
        parity = 2'b00;
        for (int i = 0; i < 9; i++) send(8'(i), 8, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovf_level", 32'(level),    32'd8);
        chk("ovf_flag",  32'(ovr),      32'h1);
        chk("ovf_head",  32'(data_out), 32'h00);
        pop_once();
        chk("ovf_pop_flag",  32'(ovr),      32'h0);
        chk("ovf_pop_level", 32'(level),    32'd7);
        chk("ovf_pop_head",  32'(data_out), 32'h01);
        for (int i = 1; i < 8; i++) expect_frame(1'b0, 1'b0, 8'(i));
        mon_en = 1'b1;
        drain("ovf_drain");
        chk("ovf_empty", 32'(level), 32'd0);

        // Short low glitch is a false start
        mon_en = 1'b0;
        rx = 1'b0;
        repeat (9) @(negedge clk);
        rx = 1'b1;
        repeat (96) @(negedge clk);
        chk("glitch_level", 32'(level), 32'd0);
        chk("glitch_rdy",   32'(rdy),   32'h0);
        mon_en = 1'b1;
        expect_frame(1'b0, 1'b0, 8'h6E);
        send(8'h6E, 8, 0, 1'b0, 1'b0, 1'b0);
        drain("glitch_next");

        // Reset mid-frame with an entry already buffered
        mon_en = 1'b0;
        send(8'h5A, 8, 0, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (144) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        chk("mrst_rdy",   32'(rdy),      32'h0);
        chk("mrst_data",  32'(data_out), 32'h0);
        chk("mrst_level", 32'(level),    32'h0);
        chk("mrst_ovr",   32'(ovr),      32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (50) @(negedge clk);
        mon_en = 1'b1;
        expect_frame(1'b0, 1'b0, 8'h3C);
        send(8'h3C, 8, 0, 1'b0, 1'b0, 1'b0);
        drain("mrst_next");

        // Line held low for 12 bit times
`ifdef UART_RX_BREAK_DETECT_EN
        begin
            int b0;
            mon_en = 1'b0;
            b0 = brk_cnt;
            rx = 1'b0;
            repeat (12 * 48) @(negedge clk);
            rx = 1'b1;
            repeat (96) @(negedge clk);
            chk("break_pulses", 32'(brk_cnt - b0), 32'd1);
            chk("break_level",  32'(level),        32'd0);
        end
`else
        expect_frame(1'b0, 1'b1, 8'h00);
        rx = 1'b0;
        repeat (12 * 48) @(negedge clk);
        rx = 1'b1;
        repeat (96) @(negedge clk);
        drain("break_frame");
        chk("break_level", 32'(level), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the UART receive controller. Oversampled asynchronous serial receiver with runtime-selectable 5–8 data bits, parity and stop-bit count. Received frames, with per-frame error flags, go into a first-word-fall-through FIFO. Sits between the rx pin and the host bus; it pairs with the existing transmit controller in loopback benches.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
FIFO_DEPTH, 8, frame entries held; power of two, >= 2
DIV_W, 16, width of the clock divider input
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output

Ports:
clk_in  in  1  system clock
n_reset_in  in  1  asynchronous active-low reset
enable_in  in  1  receiver enable; low forces IDLE, FIFO retained
rx_in  in  1  serial line, asynchronous, idle high
clk_div_in  in  DIV_W  clk_in cycles per sample tick; 0 is treated as 1
d_num_in  in  2  data bits: 00=5, 01=6, 10=7, 11=8
parity_in  in  2  00=none, 01=even, 10=odd, 11=none
s_num_in  in  1  0=1 stop bit, 1=2 stop bits
n_rd_in  in  1  active-low pop strobe; pops one entry per cycle held low while non-empty
data_out  out  8  FIFO head data; unused upper bits 0; 0 when empty
parity_error_out  out  1  FIFO head parity flag
frame_error_out  out  1  FIFO head framing flag
overrun_error_out  out  1  sticky; a frame was dropped because the FIFO was full
rx_rdy_out  out  1  FIFO non-empty
fifo_level_out  out  LVL_W  entries currently held

Behaviour:
- Reset (async assert, sync release): FSM IDLE; all counters 0; FIFO empty. All outputs 0, fifo_level_out = 0.
- rx_in passes through a 2-flop synchroniser before any use. Added latency: 2 cycles.
- Tick generator: counter runs 0..clk_div_in-1 and pulses tick on the wrap. It runs only outside IDLE and reloads to 0 on start detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH.
- IDLE -> START on a synchronised falling edge while enable_in = 1. d_num_in, parity_in and s_num_in are latched here; mid-frame changes are ignored.
- START: sample at tick OVERSAMPLE/2. If the line is high, it is a false start: return to IDLE with no push and no flags.
- Bit sampling: majority of 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit period.
- DATA: bits are received LSB first, 5–8 per the latched d_num.
- PARITY: skipped when parity is none. parity_err = XOR(data bits, parity bit) for even, and its inverse for odd.
- STOP: 1 or 2 bits. frame_err is set if any stop bit samples low.
- PUSH (1 cycle): writes {parity_err, frame_err, data} into the FIFO, then returns to IDLE. The next start can be detected in the following cycle.
- Push into a full FIFO with no pop in the same cycle: frame dropped, overrun_error_out set.
- Push and pop in the same cycle when full: both accepted, no overrun, level unchanged.
- Pop on empty: ignored.
- Pop advances the head on the next clock edge; outputs show the new head (or 0) from that edge.
- overrun_error_out is cleared by any accepted pop or by reset.
- enable_in low: FSM to IDLE in the next cycle and the partial frame is discarded. FIFO, overrun flag and pops are unaffected.
- Pointer wrap: FIFO_DEPTH is a power of two; pointers are one bit wider than the address to distinguish full from empty.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined: adds output port break_out (1 bit), reset value 0. A break is a frame whose data, parity (if enabled) and first stop bit all sample low. On a break:
  - break_out pulses high for 1 cycle;
  - nothing is pushed;
  - the FSM waits for the line to return high before entering IDLE.
- Undefined: no break_out port. The same frame is pushed as data 0x00 with frame_err = 1, and the FSM goes straight to IDLE.

Decomposition:
- Shared package uart_pkg: d_num encodings (5/6/7/8), parity encodings (NONE/EVEN/ODD), FSM state typedef, FIFO entry struct {parity_err, frame_err, data[7:0]}.
- Sub-module uart_fifo: synchronous FWFT FIFO, parametrised by DEPTH and WIDTH. It provides full, empty and level, and handles simultaneous push/pop. Shift/sample logic stays in uart_rx_fifo.

Test Plan:
- Config 8N1, clk_div_in = 27 (50 MHz / 115200 / 16). Transmit 0xA5 -> after the stop bit: rx_rdy_out = 1, data_out = 0xA5, both error flags 0, fifo_level_out = 1. One n_rd_in pulse -> empty, data_out = 0.
- Sweep all 4 d_num × 3 parity × 2 stop settings in loopback with the transmit controller, data = index -> each frame matches the index masked to the data width, no flags.
- 7E1, inject a wrong parity bit on 0x35 -> data_out = 0x35, parity_error_out = 1. Force stop bit low on 0x12 -> frame_error_out = 1.
- Send 9 frames 0x00..0x08 with no reads, FIFO_DEPTH = 8 -> level 8, overrun_error_out = 1, head 0x00, 0x08 dropped. Pop once -> overrun cleared, level 7.
- Low glitch on rx_in of 3 sample ticks -> no push, FSM back in IDLE. Assert n_reset_in mid-frame -> all outputs 0, next full frame received correctly.
- With UART_RX_BREAK_DETECT_EN, hold rx_in low for 12 bit times -> single break_out pulse, level unchanged. Without the macro -> entry 0x00 with frame_error_out = 1.
